// File: rtl/noc_vc_output_scheduler_pkg.sv
// Shared NoC parameters and types for the per-VC output scheduler.
package noc_vc_output_scheduler_pkg;

  localparam int Noc_VC_Channel    = 4;
  localparam int Noc_Data_Width    = 32;
  localparam int Noc_Flit_Head_Bit = Noc_Data_Width - 1;
  localparam int Noc_Flit_Tail_Bit = Noc_Data_Width - 2;

  typedef enum logic {
    SCHED_IDLE   = 1'b0,
    SCHED_LOCKED = 1'b1
  } noc_sched_state_e;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr wins.
module noc_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IW  = (N > 1) ? $clog2(N) : 1,
  localparam int IWP = IW + 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx
);

  logic           found_s;
  logic [IWP-1:0] sum_s;
  logic [IW-1:0]  idx_s;

  // Scan requesters starting from the priority pointer, wrapping at N.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    found_s     = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, i_ptr} + IWP'(k);
      if (sum_s >= IWP'(N)) begin
        sum_s = sum_s - IWP'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[IW-1:0];
      if (!found_s && i_req[idx_s]) begin
        found_s        = 1'b1;
        o_grant[idx_s] = 1'b1;
        o_grant_idx    = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/noc_vc_output_scheduler_chk.sv
// Protocol checker: a credit return must never arrive while that VC's counter is already full.
module noc_vc_output_scheduler_chk #(
  parameter int CHANNELS = 4
) (
  input logic                noc_clk,
  input logic                noc_rst_n,
  input logic                i_clear,
  input logic [CHANNELS-1:0] i_credit_return,
  input logic [CHANNELS-1:0] i_credit_full
);

  // Returns during a clear are dropped, so they cannot overflow.
  credit_overflow_a: assert property (@(posedge noc_clk) disable iff (!noc_rst_n)
    i_clear || ((i_credit_return & i_credit_full) == '0));

endmodule

// File: rtl/noc_vc_output_scheduler.sv
// Output-side VC scheduler: round-robin over eligible VCs, wormhole lock head->tail, per-VC credits.
module noc_vc_output_scheduler
  import noc_vc_output_scheduler_pkg::*;
#(
  parameter  int CHANNELS   = Noc_VC_Channel,
  parameter  int FLIT_WIDTH = Noc_Data_Width,
  parameter  int CREDITS    = 8,
  localparam int CW         = $clog2(CREDITS + 1),
  localparam int VW         = $clog2(CHANNELS)
) (
  input  logic                                noc_clk,
  input  logic                                noc_rst_n,
  input  logic                                i_clear,
  input  logic [CHANNELS-1:0]                 i_vc_empty,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] i_vc_flit,
  output logic [CHANNELS-1:0]                 o_vc_pop,
  output logic [CHANNELS-1:0]                 o_valid,
  output logic [FLIT_WIDTH-1:0]               o_flit,
  input  logic [CHANNELS-1:0]                 i_credit_return,
  output logic                                o_locked,
  output logic [VW-1:0]                       o_lock_vc
);

  localparam int HEAD_BIT = FLIT_WIDTH - 1;
  localparam int TAIL_BIT = FLIT_WIDTH - 2;

  noc_sched_state_e state_r, state_s;
  logic [VW-1:0]    lock_vc_r, lock_vc_s;
  logic [VW-1:0]    rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]    credit_r [CHANNELS];

  logic [CHANNELS-1:0]   eligible_s;
  logic [CHANNELS-1:0]   arb_grant_s;
  logic [CHANNELS-1:0]   grant_s;
  logic [CHANNELS-1:0]   credit_full_s;
  logic [VW-1:0]         grant_idx_s;
  logic                  grant_any_s;
  logic [FLIT_WIDTH-1:0] grant_flit_s;

  logic [CHANNELS-1:0]   valid_r;
  logic [FLIT_WIDTH-1:0] flit_r;

  // A VC may send when it has data, a downstream credit, and is not blocked by another VC's lock.
  always_comb begin
    eligible_s    = '0;
    credit_full_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      eligible_s[i]    = !i_vc_empty[i] && (credit_r[i] != '0) &&
                         ((state_r == SCHED_IDLE) || (lock_vc_r == VW'(i)));
      credit_full_s[i] = (credit_r[i] == CW'(CREDITS));
    end
  end

  noc_rr_arbiter #(.N(CHANNELS)) u_arb (
    .i_req       (eligible_s),
    .i_ptr       (rr_ptr_r),
    .o_grant     (arb_grant_s),
    .o_grant_idx (grant_idx_s)
  );

  // Pop is suppressed while in reset or clearing so the FIFO never loses a flit.
  always_comb begin
    grant_any_s  = noc_rst_n && !i_clear && (|arb_grant_s);
    grant_flit_s = i_vc_flit[grant_idx_s];
    if (grant_any_s) begin
      grant_s = arb_grant_s;
    end else begin
      grant_s = '0;
    end
  end

  assign o_vc_pop = grant_s;

  // Lock FSM next-state and round-robin pointer update.
  always_comb begin
    state_s   = state_r;
    lock_vc_s = lock_vc_r;
    rr_ptr_s  = rr_ptr_r;
    if (i_clear) begin
      state_s   = SCHED_IDLE;
      lock_vc_s = '0;
      rr_ptr_s  = '0;
    end else if (grant_any_s) begin
      case (state_r)
        SCHED_IDLE: begin
          if (grant_idx_s == VW'(CHANNELS - 1)) begin
            rr_ptr_s = '0;
          end else begin
            rr_ptr_s = grant_idx_s + VW'(1'b1);
          end
          if (grant_flit_s[HEAD_BIT] && !grant_flit_s[TAIL_BIT]) begin
            state_s   = SCHED_LOCKED;
            lock_vc_s = grant_idx_s;
          end else begin
            state_s = SCHED_IDLE;
          end
        end
        SCHED_LOCKED: begin
          if (grant_flit_s[TAIL_BIT]) begin
            state_s = SCHED_IDLE;
          end else begin
            state_s = SCHED_LOCKED;
          end
        end
        default: begin
          state_s = SCHED_IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // FSM, lock owner and priority pointer registers.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_r   <= SCHED_IDLE;
      lock_vc_r <= '0;
      rr_ptr_r  <= '0;
    end else begin
      state_r   <= state_s;
      lock_vc_r <= lock_vc_s;
      rr_ptr_r  <= rr_ptr_s;
    end
  end

  // Credit counters: send and return in the same cycle cancel; a return at full saturates.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) credit_r[i] <= CW'(CREDITS);
    end else if (i_clear) begin
      for (int i = 0; i < CHANNELS; i++) credit_r[i] <= CW'(CREDITS);
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        case ({grant_s[i], i_credit_return[i]})
          2'b10: credit_r[i] <= credit_r[i] - CW'(1'b1);
          2'b01: begin
            if (!credit_full_s[i]) begin
              credit_r[i] <= credit_r[i] + CW'(1'b1);
            end else begin
              credit_r[i] <= credit_r[i];
            end
          end
          default: credit_r[i] <= credit_r[i];
        endcase
      end
    end
  end

  // Link output register; the flit bus holds its last value when idle.
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      valid_r <= '0;
      flit_r  <= '0;
    end else if (i_clear) begin
      valid_r <= '0;
      flit_r  <= '0;
    end else if (grant_any_s) begin
      valid_r <= grant_s;
      flit_r  <= grant_flit_s;
    end else begin
      valid_r <= '0;
    end
  end

  assign o_valid   = valid_r;
  assign o_flit    = flit_r;
  assign o_locked  = (state_r == SCHED_LOCKED);
  assign o_lock_vc = lock_vc_r;

  noc_vc_output_scheduler_chk #(.CHANNELS(CHANNELS)) u_chk (
    .noc_clk         (noc_clk),
    .noc_rst_n       (noc_rst_n),
    .i_clear         (i_clear),
    .i_credit_return (i_credit_return),
    .i_credit_full   (credit_full_s)
  );

endmodule
